// File: rtl/color_sequence_monitor.sv
// Colour-code sequence monitor: decodes the code to RGB and tracks a 2->3->4->5 cycle.
// Optional saturating error counter is built in when COLOR_MON_ERRCNT_EN is defined.
module color_sequence_monitor #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned LOCK_THRESH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  color,
  output logic [11:0] rgb,
  output logic        locked,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam logic [1:0] StSearch = 2'd0;
  localparam logic [1:0] StTrack  = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  localparam logic [3:0] HoldTarget = 4'(HOLD_CYCLES);
  localparam logic [7:0] LockTarget = 8'(LOCK_THRESH);

  function automatic logic is_valid(input logic [3:0] c);
    return (c >= 4'd2) && (c <= 4'd5);
  endfunction

  function automatic logic [3:0] next_code(input logic [3:0] c);
    return (c == 4'd5) ? 4'd2 : c + 4'd1;
  endfunction

  function automatic logic [11:0] decode(input logic [3:0] c);
    logic [11:0] v;
    case (c)
      4'd2:    v = 12'hF00;
      4'd3:    v = 12'h0F0;
      4'd4:    v = 12'h00F;
      4'd5:    v = 12'hFFF;
      default: v = 12'h000;
    endcase
    return v;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [3:0]  prev_q, prev_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic [11:0] rgb_q, rgb_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;

  logic changed;
  logic good;
  logic violation;

  always_comb begin
    changed   = (color != prev_q);
    good      = changed && is_valid(prev_q) && (color == next_code(prev_q)) &&
                (hold_cnt_q == HoldTarget);
    violation = changed ? !good : (hold_cnt_q == HoldTarget);

    prev_d     = color;
    hold_cnt_d = changed ? 4'd1 : ((hold_cnt_q == 4'd15) ? 4'd15 : hold_cnt_q + 4'd1);
    rgb_d      = decode(color);

    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      StSearch: begin
        // Only a change between two valid codes starts tracking; the change itself is not good.
        if (changed && is_valid(prev_q) && is_valid(color)) begin
          state_d    = StTrack;
          good_cnt_d = 8'd0;
        end
      end
      StTrack: begin
        if (violation) begin
          state_d    = StSearch;
          good_cnt_d = 8'd0;
        end else if (good) begin
          good_cnt_d = good_cnt_q + 8'd1;
          if (good_cnt_d >= LockTarget) begin
            state_d = StLocked;
          end
        end
      end
      StLocked: begin
        if (violation) begin
          state_d    = StSearch;
          good_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d    = StSearch;
        good_cnt_d = 8'd0;
      end
    endcase

    locked_d = (state_d == StLocked);
    err_d    = (state_q == StLocked) && violation;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StSearch;
      prev_q     <= 4'd0;
      hold_cnt_q <= 4'd0;
      good_cnt_q <= 8'd0;
      rgb_q      <= 12'h000;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      hold_cnt_q <= hold_cnt_d;
      good_cnt_q <= good_cnt_d;
      rgb_q      <= rgb_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

`ifdef COLOR_MON_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'h00;
`endif

  assign rgb    = rgb_q;
  assign locked = locked_q;
  assign err    = err_q;

endmodule

// File: tb/tb_color_sequence_monitor.sv
// Directed bench for color_sequence_monitor: vector table plus lock/skip/saturation/reset sequences.
module tb_color_sequence_monitor;

`ifdef COLOR_MON_ERRCNT_EN
  localparam bit ErrCntEn = 1'b1;
`else
  localparam bit ErrCntEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  color;
  logic [11:0] rgb;
  logic        locked;
  logic        err;
  logic [7:0]  err_count;

  int checks;
  int failures;
  int model_cnt;

  color_sequence_monitor #(
    .HOLD_CYCLES(2),
    .LOCK_THRESH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .color    (color),
    .rgb      (rgb),
    .locked   (locked),
    .err      (err),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0]  color;
    logic [11:0] rgb;
    logic        locked;
    logic        err;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t vecs[16];
  logic [3:0] lock_seq[12];

  task automatic step(input logic [3:0] c);
    color = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_cnt(input int n);
    return ErrCntEn ? 8'(n) : 8'd0;
  endfunction

  // From SEARCH: 6 invalidates prev, then the full cycle ends locked with prev=3, hold=2.
  task automatic relock(input string name);
    step(4'd6);
    for (int i = 0; i < 12; i++) step(lock_seq[i]);
    chk({name, " locked"}, {11'd0, locked}, 12'd1);
  endtask

  task automatic overstay(input string name);
    step(4'd4);
    step(4'd4);
    step(4'd4);
    if (model_cnt < 255) model_cnt++;
    chk({name, " err"}, {11'd0, err}, 12'd1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    model_cnt = 0;
    lock_seq  = '{4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4, 4'd5, 4'd5, 4'd2, 4'd2, 4'd3, 4'd3};

    vecs[0]  = '{4'd2, 12'hF00, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{4'd2, 12'hF00, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{4'd3, 12'h0F0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{4'd3, 12'h0F0, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{4'd4, 12'h00F, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{4'd4, 12'h00F, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{4'd5, 12'hFFF, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{4'd5, 12'hFFF, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{4'd2, 12'hF00, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{4'd2, 12'hF00, 1'b0, 1'b0, 8'd0};
    vecs[10] = '{4'd3, 12'h0F0, 1'b1, 1'b0, 8'd0};
    vecs[11] = '{4'd3, 12'h0F0, 1'b1, 1'b0, 8'd0};
    vecs[12] = '{4'd4, 12'h00F, 1'b1, 1'b0, 8'd0};
    vecs[13] = '{4'd4, 12'h00F, 1'b1, 1'b0, 8'd0};
    vecs[14] = '{4'd4, 12'h00F, 1'b0, 1'b1, 8'd1};
    vecs[15] = '{4'd6, 12'h000, 1'b0, 1'b0, 8'd1};

    // Reset with an invalid code on the input
    rst   = 1'b0;
    color = 4'd9;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset rgb", rgb, 12'h000);
    chk("reset locked", {11'd0, locked}, 12'd0);
    chk("reset err", {11'd0, err}, 12'd0);
    chk("reset err_count", {4'd0, err_count}, 12'd0);
    rst = 1'b1;

    // Lock-up then overstay
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].color);
      chk($sformatf("vec%0d rgb", i), rgb, vecs[i].rgb);
      chk($sformatf("vec%0d locked", i), {11'd0, locked}, {11'd0, vecs[i].locked});
      chk($sformatf("vec%0d err", i), {11'd0, err}, {11'd0, vecs[i].err});
      chk($sformatf("vec%0d err_count", i), {4'd0, err_count}, {4'd0, exp_cnt(vecs[i].ecnt)});
    end
    model_cnt = 1;

    // Wrap 5->2 while locked, then a 3->5 skip
    relock("skip relock");
    step(4'd4); step(4'd4); step(4'd5); step(4'd5); step(4'd2);
    chk("wrap locked", {11'd0, locked}, 12'd1);
    chk("wrap err", {11'd0, err}, 12'd0);
    step(4'd2); step(4'd3); step(4'd3);
    chk("pre-skip locked", {11'd0, locked}, 12'd1);
    step(4'd5);
    model_cnt++;
    chk("skip err", {11'd0, err}, 12'd1);
    chk("skip locked", {11'd0, locked}, 12'd0);
    chk("skip err_count", {4'd0, err_count}, {4'd0, exp_cnt(model_cnt)});
    step(4'd5);
    chk("skip err pulse width", {11'd0, err}, 12'd0);
    step(4'd6);
    chk("invalid rgb", rgb, 12'h000);
    chk("invalid err", {11'd0, err}, 12'd0);
    step(4'd6);
    chk("invalid hold err", {11'd0, err}, 12'd0);
    chk("invalid hold locked", {11'd0, locked}, 12'd0);

    // Saturation of the error counter
    for (int n = 0; n < 300; n++) begin
      relock($sformatf("sat%0d", n));
      overstay($sformatf("sat%0d", n));
    end
    chk("sat err_count", {4'd0, err_count}, {4'd0, exp_cnt(model_cnt)});
    chk("sat err_count abs", {4'd0, err_count}, ErrCntEn ? 12'd255 : 12'd0);

    // Reset in the middle of a lock
    relock("midlock relock");
    rst = 1'b0;
    step(4'd4);
    chk("midlock rgb", rgb, 12'h000);
    chk("midlock locked", {11'd0, locked}, 12'd0);
    chk("midlock err", {11'd0, err}, 12'd0);
    chk("midlock err_count", {4'd0, err_count}, 12'd0);
    rst = 1'b1;
    step(4'd4);
    chk("post-reset err", {11'd0, err}, 12'd0);
    chk("post-reset locked", {11'd0, locked}, 12'd0);
    chk("post-reset rgb", rgb, 12'h00F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
